dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: the pipeline memory stage (CPU port, load/store)
//  and an external DMA/debug port. Sequences each access through a fixed-latency memory, returns read data
//  with a one-cycle ack, and drives a stall to hold the memory stage until its access completes.
//  Fixed priority CPU > DMA, with a starvation guard that forces a DMA grant.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  MEM_LAT     1   cycles from mem_en to valid mem_rdata (legal 1..4)
//  STARVE_MAX  4   consecutive CPU grants while DMA waits before DMA is forced (legal 1..15)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  cpu_req    in   1   CPU access request; held with cpu_we/addr/wdata until cpu_ack
//  cpu_we     in   1   1=store, 0=load
//  cpu_addr   in   AW  CPU byte address
//  cpu_wdata  in   DW  CPU store data
//  cpu_ack    out  1   one-cycle completion pulse
//  cpu_rdata  out  DW  load data, valid with cpu_ack, held until next CPU load ack
//  cpu_stall  out  1   cpu_req & ~cpu_ack (combinational), freezes MEM/WB pipeline registers
//  dma_req    in   1   DMA access request; held until dma_ack
//  dma_we     in   1   1=write, 0=read
//  dma_addr   in   AW  DMA address
//  dma_wdata  in   DW  DMA write data
//  dma_ack    out  1   one-cycle completion pulse
//  dma_rdata  out  DW  read data, valid with dma_ack, held until next DMA read ack
//  mem_en     out  1   memory access strobe, one cycle per access
//  mem_we     out  1   memory write enable, qualified by mem_en
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid MEM_LAT cycles after mem_en
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, starvation counter=0, latched request cleared; async, takes effect immediately.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//    IDLE: if any req, register winner id, we, addr, wdata; go ISSUE. Else stay.
//    ISSUE: mem_en=1, mem_we/addr/wdata from latch; load lat counter=MEM_LAT-1; go WAIT.
//    WAIT: decrement; at count 0 capture mem_rdata into the winner's rdata register (reads only); go RESP.
//    RESP: winner's ack=1 for exactly one cycle; go IDLE.
//  - Latency: req seen in IDLE at cycle 0 -> mem_en cycle 1 -> ack cycle 2+MEM_LAT. Reads and writes use the same timing.
//    Peak throughput: one access per MEM_LAT+3 cycles.
//  - Arbitration (IDLE only): DMA wins if dma_req & (~cpu_req | starve==STARVE_MAX), else CPU wins.
//  - Starvation counter (4b): +1 on each CPU grant while dma_req=1; saturates at STARVE_MAX;
//    cleared on DMA grant or when dma_req=0 in IDLE.
//  - mem_addr/mem_we/mem_wdata are 0 outside ISSUE; mem_en never asserted outside ISSUE.
//  - A requester that drops req before its ack is a protocol violation. The access still completes and acks;
//    no abort path.
//  - Simultaneous new requests arriving during ISSUE/WAIT/RESP are ignored until IDLE. Ack and a new
//    grant never coincide.
//  - Reset mid-access (ISSUE/WAIT/RESP): access abandoned, no ack issued, rdata registers cleared.
// STRUCTURE
//  - Package dmem_arb_pkg: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3),
//    grant ids GNT_CPU=1'b0/GNT_DMA=1'b1, MEM_LAT_MAX=4.
//  - Sub-module arb_starve_ctr: saturating starvation counter with inc/clr/sat-flag ports.
//    FSM, latch and datapath muxes stay in the top.
// TESTING
//  1. MEM_LAT=1, mem[0x10]=0xDEADBEEF, CPU load 0x10 at cycle 0 -> mem_en cycle 1, cpu_ack+cpu_rdata=0xDEADBEEF
//     cycle 3, cpu_stall=1 cycles 0-2, 0 at cycle 3.
//  2. DMA write 0x20<=0x12345678, then CPU load 0x20 -> dma_ack once, then cpu_rdata=0x12345678; dma_rdata unchanged.
//  3. cpu_req and dma_req held continuously, STARVE_MAX=4 -> grant order CPU,CPU,CPU,CPU,DMA repeating;
//     counter back to 0 after each DMA grant.
//  4. rst pulsed during WAIT -> all outputs 0 same cycle, no ack. Request after reset serviced with nominal latency.
//  5. MEM_LAT=3 build: CPU load at cycle 0 -> mem_en cycle 1, ack cycle 5. Assert mem_en one cycle per ack, never in IDLE.
//  6. CPU store 0x04<=0xA5A5A5A5 after a load returned 0x1 -> mem_we=1 with mem_en, cpu_ack cycle 3, cpu_rdata stays 0x1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding, grant ids
// and sizing constants for the latency and starvation counters.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CW      = $clog2(MEM_LAT_MAX);
  localparam int STARVE_W    = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive CPU grants taken while the DMA port waits;
// sat tells the arbiter to force the next grant to DMA.
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                clr,
  output logic                sat,
  output logic [STARVE_W-1:0] cnt
);

  assign sat = (cnt == STARVE_W'(STARVE_MAX));

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage and a
// DMA/debug port, sequencing one fixed-latency access at a time.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t          state, state_nxt;
  logic                gnt_q;
  logic                we_q;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;
  logic [LAT_CW-1:0]   lat_cnt;
  logic                in_idle;
  logic                in_issue;
  logic                dma_win;
  logic                starve_sat;
  logic                starve_inc;
  logic                starve_clr;
  logic [STARVE_W-1:0] starve_cnt;
  logic                cap_rd;

  assign in_idle  = (state == IDLE);
  assign in_issue = (state == ISSUE);
  assign dma_win  = dma_req & (~cpu_req | starve_sat);

  assign starve_inc = in_idle & cpu_req & ~dma_win & dma_req;
  assign starve_clr = in_idle & (dma_win | ~dma_req);

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk(clk),
    .rst(rst),
    .inc(starve_inc),
    .clr(starve_clr),
    .sat(starve_sat),
    .cnt(starve_cnt)
  );

  // NOTE: next state is defaulted before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (cpu_req || dma_req) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (lat_cnt == '0) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign cap_rd = (state == WAIT) && (lat_cnt == '0) && !we_q;

  // NOTE: the read-data holding registers are plain flops, not a memory, so
  // they are cleared by reset like the rest of the request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= GNT_CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lat_cnt   <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      if (in_idle && (cpu_req || dma_req)) begin
        gnt_q   <= dma_win ? GNT_DMA : GNT_CPU;
        we_q    <= dma_win ? dma_we : cpu_we;
        addr_q  <= dma_win ? dma_addr : cpu_addr;
        wdata_q <= dma_win ? dma_wdata : cpu_wdata;
      end
      if (in_issue) begin
        lat_cnt <= LAT_CW'(MEM_LAT - 1);
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (cap_rd && (gnt_q == GNT_CPU)) cpu_rdata <= mem_rdata;
      if (cap_rd && (gnt_q == GNT_DMA)) dma_rdata <= mem_rdata;
    end
  end

  assign mem_en    = in_issue;
  assign mem_we    = in_issue & we_q;
  assign mem_addr  = in_issue ? addr_q  : '0;
  assign mem_wdata = in_issue ? wdata_q : '0;

  assign cpu_ack = (state == RESP) && (gnt_q == GNT_CPU);
  assign dma_ack = (state == RESP) && (gnt_q == GNT_DMA);
  assign busy    = !in_idle;

  // Gated with rst so the stall drops in the same cycle reset is applied.
  assign cpu_stall = cpu_req & ~cpu_ack & ~rst;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a MEM_LAT=1 instance for the main
// scenarios and a MEM_LAT=3 instance for the longer-latency timing.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        cpu_req3, cpu_we3, cpu_ack3, cpu_stall3;
  logic [31:0] cpu_addr3, cpu_wdata3, cpu_rdata3;
  logic        dma_req3, dma_we3, dma_ack3;
  logic [31:0] dma_addr3, dma_wdata3, dma_rdata3;
  logic        mem_en3, mem_we3, busy3;
  logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;

  dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
    .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3), .cpu_stall(cpu_stall3),
    .dma_req(dma_req3), .dma_we(dma_we3), .dma_addr(dma_addr3), .dma_wdata(dma_wdata3),
    .dma_ack(dma_ack3), .dma_rdata(dma_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory models: read data appears MEM_LAT cycles after the strobe cycle.
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] rd1;
  logic [31:0] rd3 [3];

  always @(posedge clk) begin
    rd1 <= mem1[mem_addr[7:2]];
    if (mem_en && mem_we) mem1[mem_addr[7:2]] <= mem_wdata;
  end
  assign mem_rdata = rd1;

  always @(posedge clk) begin
    rd3[0] <= mem3[mem_addr3[7:2]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
    if (mem_en3 && mem_we3) mem3[mem_addr3[7:2]] <= mem_wdata3;
  end
  assign mem_rdata3 = rd3[2];

  int en_cnt3 = 0;
  int ack_cnt3 = 0;
  int idle_en_viol = 0;
  always @(negedge clk) begin
    if (mem_en3) en_cnt3++;
    if (cpu_ack3 || dma_ack3) ack_cnt3++;
    if ((mem_en3 && !busy3) || (mem_en && !busy)) idle_en_viol++;
  end

  task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int lat);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!cpu_ack && lat < 20);
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic dma_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int lat);
    @(negedge clk);
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!dma_ack && lat < 20);
    dma_req = 1'b0; dma_we = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({cpu_ack, cpu_stall, dma_ack, mem_en, mem_we, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {cpu_ack, cpu_stall, dma_ack, mem_en, mem_we, busy});
    end
    checks++;
    if ({cpu_rdata, dma_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      errors++; $display("FAIL reset_data: got %h expected 0",
                         {cpu_rdata, dma_rdata, mem_addr, mem_wdata});
    end
    checks++;
    if (u_dut1.u_starve.cnt !== 4'd0) begin
      errors++; $display("FAIL reset_starve: got %0d expected 0", u_dut1.u_starve.cnt);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cpu_load();
    int lat;
    dma_op(1'b1, 32'h10, 32'hDEADBEEF, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL dma_setup_lat: got %0d expected 3", lat); end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
    #1;
    checks++;
    if ({cpu_stall, mem_en, cpu_ack} !== 3'b100) begin
      errors++; $display("FAIL load_c0: got %b expected 100", {cpu_stall, mem_en, cpu_ack});
    end
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, cpu_stall, busy} !== 4'b1011 || mem_addr !== 32'h10) begin
      errors++; $display("FAIL load_c1: got %b/%h expected 1011/00000010",
                         {mem_en, mem_we, cpu_stall, busy}, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({mem_en, cpu_stall, cpu_ack} !== 3'b010 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL load_c2: got %b/%h expected 010/0",
                         {mem_en, cpu_stall, cpu_ack}, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({cpu_ack, cpu_stall} !== 2'b10 || cpu_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_c3: got %b/%h expected 10/deadbeef",
                         {cpu_ack, cpu_stall}, cpu_rdata);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_ack, busy} !== 2'b00 || cpu_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_c4: got %b/%h expected 00/deadbeef",
                         {cpu_ack, busy}, cpu_rdata);
    end
  endtask

  task automatic test_dma_then_cpu();
    int lat;
    dma_op(1'b1, 32'h20, 32'h12345678, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL dma_wr_lat: got %0d expected 3", lat); end
    @(negedge clk);
    checks++;
    if (dma_ack !== 1'b0) begin errors++; $display("FAIL dma_ack_once: got 1 expected 0"); end
    cpu_op(1'b0, 32'h20, 32'h0, lat);
    checks++;
    if (lat !== 3 || cpu_rdata !== 32'h12345678) begin
      errors++; $display("FAIL cpu_rd_after_dma: got %0d/%h expected 3/12345678", lat, cpu_rdata);
    end
    checks++;
    if (dma_rdata !== 32'h0) begin
      errors++; $display("FAIL dma_rdata_hold: got %h expected 0", dma_rdata);
    end
  endtask

  task automatic test_store();
    int lat;
    dma_op(1'b1, 32'h08, 32'h1, lat);
    cpu_op(1'b0, 32'h08, 32'h0, lat);
    checks++;
    if (cpu_rdata !== 32'h1) begin
      errors++; $display("FAIL store_pre_load: got %h expected 1", cpu_rdata);
    end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h04; cpu_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h04 || mem_wdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL store_c1: got %b/%h/%h expected 11/4/a5a5a5a5",
                         {mem_en, mem_we}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({mem_we, cpu_ack} !== 2'b00) begin
      errors++; $display("FAIL store_c2: got %b expected 00", {mem_we, cpu_ack});
    end
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h1) begin
      errors++; $display("FAIL store_c3: got %b/%h expected 1/1", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_op(1'b0, 32'h04, 32'h0, lat);
    checks++;
    if (cpu_rdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL store_readback: got %h expected a5a5a5a5", cpu_rdata);
    end
  endtask

  task automatic test_starvation();
    logic exp_dma;
    logic [3:0] exp_cnt;
    int n;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h30; dma_wdata = 32'h55;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(cpu_ack || dma_ack) && n < 20);
      exp_dma = ((k % 5) == 4);
      exp_cnt = exp_dma ? 4'd0 : 4'((k % 5) + 1);
      checks++;
      if ({cpu_ack, dma_ack} !== {!exp_dma, exp_dma}) begin
        errors++; $display("FAIL grant_order[%0d]: got cpu/dma %b expected %b",
                           k, {cpu_ack, dma_ack}, {!exp_dma, exp_dma});
      end
      checks++;
      if (u_dut1.u_starve.cnt !== exp_cnt) begin
        errors++; $display("FAIL starve_cnt[%0d]: got %0d expected %0d",
                           k, u_dut1.u_starve.cnt, exp_cnt);
      end
      checks++;
      if (n !== ((k == 0) ? 3 : 4)) begin
        errors++; $display("FAIL grant_gap[%0d]: got %0d expected %0d", k, n, (k == 0) ? 3 : 4);
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    int acks;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (u_dut1.state !== dmem_arb_pkg::WAIT) begin
      errors++; $display("FAIL rst_mid_state: got %0d expected 2", u_dut1.state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, cpu_ack, cpu_stall, mem_en, dma_ack} !== 5'b0 ||
        {cpu_rdata, dma_rdata, mem_addr} !== 96'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b/%h expected 0/0",
                         {busy, cpu_ack, cpu_stall, mem_en, dma_ack},
                         {cpu_rdata, dma_rdata, mem_addr});
    end
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack || busy) acks++;
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL rst_no_ack: got %0d expected 0", acks); end
    cpu_op(1'b0, 32'h10, 32'h0, lat);
    checks++;
    if (lat !== 3 || cpu_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rst_recover: got %0d/%h expected 3/deadbeef", lat, cpu_rdata);
    end
  endtask

  task automatic test_mem_lat3();
    int n;
    int en_seen;
    @(negedge clk);
    dma_req3 = 1'b1; dma_we3 = 1'b1; dma_addr3 = 32'h10; dma_wdata3 = 32'hCAFEF00D;
    n = 0;
    do begin @(negedge clk); n++; end while (!dma_ack3 && n < 20);
    dma_req3 = 1'b0; dma_we3 = 1'b0;
    checks++;
    if (n !== 5) begin errors++; $display("FAIL lat3_dma_wr: got %0d expected 5", n); end
    @(negedge clk);
    cpu_req3 = 1'b1; cpu_we3 = 1'b0; cpu_addr3 = 32'h10;
    n = 0;
    en_seen = 0;
    do begin
      @(negedge clk); n++;
      if (mem_en3) en_seen = en_seen + ((n == 1) ? 1 : 100);
    end while (!cpu_ack3 && n < 20);
    cpu_req3 = 1'b0;
    checks++;
    if (n !== 5 || cpu_rdata3 !== 32'hCAFEF00D) begin
      errors++; $display("FAIL lat3_load: got %0d/%h expected 5/cafef00d", n, cpu_rdata3);
    end
    checks++;
    if (en_seen !== 1) begin
      errors++; $display("FAIL lat3_en_cycle: got %0d expected 1", en_seen);
    end
    @(negedge clk);
    checks++;
    if (en_cnt3 !== ack_cnt3 || en_cnt3 !== 2) begin
      errors++; $display("FAIL lat3_en_per_ack: got %0d/%0d expected 2/2", en_cnt3, ack_cnt3);
    end
    checks++;
    if (idle_en_viol !== 0) begin
      errors++; $display("FAIL mem_en_idle: got %0d expected 0", idle_en_viol);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    cpu_req3 = 1'b0; cpu_we3 = 1'b0; cpu_addr3 = '0; cpu_wdata3 = '0;
    dma_req3 = 1'b0; dma_we3 = 1'b0; dma_addr3 = '0; dma_wdata3 = '0;
    test_reset();
    test_cpu_load();
    test_dma_then_cpu();
    test_store();
    test_starvation();
    test_reset_mid();
    test_mem_lat3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
